// File: rtl/multicycle_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_mem_responder_if
// Purpose  : Request/response bundle between the multi-cycle datapath and its
//            memory responder (adds req_wstrb when MEM_BYTE_STROBE_EN is set).
// Revision : 1.0
// ============================================================================
interface multicycle_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
`ifdef MEM_BYTE_STROBE_EN
    logic [3:0]  req_wstrb;
`endif
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

`ifdef MEM_BYTE_STROBE_EN
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
`else
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
`endif
endinterface
`default_nettype wire

// File: rtl/multicycle_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_mem_responder
// Purpose  : Fixed-latency unified instruction/data word memory for the
//            multi-cycle MIPS datapath. Option macro: MEM_BYTE_STROBE_EN.
// Revision : 1.0
// ============================================================================
module multicycle_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    multicycle_mem_responder_if.slave bus
);
    localparam int         c_IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                w_accept;
    logic                r_write;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic [3:0]          w_req_wstrb;
    logic                w_err;
    logic                w_do_write;
    logic [c_IDX_W-1:0]  w_idx;
    logic [31:0]         w_wmerge;
    logic [31:0]         r_mem [DEPTH_WORDS];

`ifdef MEM_BYTE_STROBE_EN
    assign w_req_wstrb = bus.req_wstrb;
`else
    assign w_req_wstrb = 4'hF;
`endif

    // All decisions after acceptance use the latched copy of the request.
    assign w_idx      = r_addr[c_IDX_W+1:2];
    assign w_err      = (r_addr[1:0] != 2'b00) || (r_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_do_write = (r_state == S_RESP) && r_write && !w_err;

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_merge
        assign w_wmerge[8*gi +: 8] = r_wstrb[gi] ? r_wdata[8*gi +: 8]
                                                 : r_mem[w_idx][8*gi +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_write <= bus.req_write;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_wstrb <= w_req_wstrb;
            end
        end
    end

    // Array is deliberately not reset; an access aborted by reset never reaches RESP.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[w_idx] <= w_wmerge;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_accept       = 1'b0;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = 32'd0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = c_CNT_LOAD;
                    w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = w_err;
                if (!w_err && !r_write) begin
                    bus.resp_rdata = r_mem[w_idx];
                end
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end
endmodule
`default_nettype wire
